gobou_net_reader: RTL and testbench
===================================

Name: gobou_net_reader

Overview:
Read-side sequencer for the gobou network-weight RAM. It issues word addresses to the RAM's registered-address read port and captures read_data one cycle later. It streams the words to the FC datapath over a valid/ready interface. A 4-entry buffer absorbs downstream stalls without losing words already in flight.

Parameters:
DWIDTH, 16, signed weight word width (from gobou.vh)
NETSIZE, 14, RAM address width; the RAM holds 2**NETSIZE words (from gobou.vh)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset, synchronous, active-high
req  in  1  start pulse; sampled only in IDLE
base_addr  in  NETSIZE  first word address; latched on accepted req
count  in  NETSIZE+1  number of words to read; latched on accepted req
busy  out  1  high from accepted req until done
done  out  1  one-cycle pulse after the final word handshake
mem_addr  out  NETSIZE  RAM address, driven from a register
read_data  in  DWIDTH  RAM data, valid the cycle after mem_addr is presented
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts the word
out_data  out  DWIDTH  signed weight word (buffer head)
out_last  out  1  high with the final word of the segment

Behaviour:
- Reset values: busy=0, done=0, mem_addr=0, out_valid=0, out_data=0, out_last=0. On reset the FSM returns to IDLE, the buffer is flushed, in-flight reads are discarded and the counters are cleared. This applies mid-segment too.
- FSM states: IDLE, RUN, FLUSH.
- IDLE, req=1, count!=0:
  - latch next_addr=base_addr, issue_left=count, recv_left=count
  - busy=1 next cycle; go to RUN
- IDLE, req=1, count=0: no reads issued; done pulses next cycle; busy stays 0.
- req outside IDLE is ignored.
- Issue rule in RUN: issue when issue_left!=0 and (occupancy+inflight)<4. Occupancy and inflight are registered, so out_ready has no combinational path to mem_addr.
- On issue:
  - mem_addr<=next_addr
  - next_addr increments modulo 2**NETSIZE; wrap from 2**NETSIZE-1 to 0 is legal
  - issue_left decrements
  - inflight<=1
- Without issue, mem_addr holds its value and inflight<=0.
- Capture: when inflight=1, read_data is pushed into the buffer that cycle. The write enters at the tail and is visible at out_data from the next cycle.
- Tagging: the pushed entry is tagged last when recv_left==1; recv_left decrements on push.
- Output: out_valid = buffer non-empty; out_data and out_last come from the head entry.
  - Pop occurs on out_valid&&out_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
- Throughput: 1 word/cycle sustained with out_ready held high. First out_valid appears 3 cycles after req (req, issue, capture).
- Move to FLUSH when issue_left reaches 0.
- FLUSH to IDLE on the handshake of the last-tagged entry. done=1 in the following cycle and busy=0 in that same cycle.
- The buffer never overflows: the issue rule bounds occupancy+inflight at 4.
- This block never writes the RAM. The write port (mem_we/write_data) belongs to the loader. Concurrent writes to addresses of an active segment are a system-level error; the read returns whatever the RAM produces.

Optional Feature:
GOBOU_NET_READER_STAT_EN
- Defined:
  - extra port stall_cycles (out, 32 bits)
  - counts cycles with out_valid=1 and out_ready=0
  - cleared on rst and on every accepted req; saturates at 2**32-1
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- gobou.vh (shared) holds DWIDTH and NETSIZE.
- FSM state encodings are localparams local to the module.
- Sub-module gobou_net_reader_fifo:
  - 4-entry, DWIDTH+1 wide (data plus last tag)
  - push, pop, occupancy, head outputs
  - synchronous active-high rst

Test Plan:
- Setup: RAM preloaded mem[i]=i*3 (truncated to DWIDTH).
- req with base=10, count=5, out_ready=1 -> out_data 30,33,36,39,42 on consecutive cycles. First out_valid 3 cycles after req; out_last only with 42; done one cycle after; busy low with done.
- base=2**NETSIZE-2, count=4 -> addresses 16382,16383,0,1; data wraps accordingly; no gaps.
- count=8 with out_ready toggling 1,0,0,1 repeating -> all 8 words delivered in order, none lost or duplicated. out_data stable while stalled; mem_addr stops advancing once occupancy+inflight=4.
- count=0 req -> zero out_valid; done pulses the next cycle; busy never rises. A req while busy on a count=3 segment -> ignored; exactly 3 words out.
- rst asserted mid-segment with 2 words buffered -> next cycle out_valid=0, busy=0, mem_addr=0. A new req with base=0, count=1 yields 0 with out_last=1.
- With GOBOU_NET_READER_STAT_EN: count=4, out_ready low for 6 cycles after the first valid -> stall_cycles=6; a new req clears it to 0.

Source files
------------

// File: rtl/gobou_net_reader_pkg.sv
// Shared types and sizing for the gobou network-weight read path.
// DWIDTH / NETSIZE defaults mirror the gobou system configuration.
package gobou_net_reader_pkg;

  // Default weight word width and RAM address width.
  localparam int GOBOU_DWIDTH  = 16;
  localparam int GOBOU_NETSIZE = 14;

  // Elastic buffer geometry: depth, pointer width and occupancy width (0..4).
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int OCC_W      = 3;

  // Reader sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/gobou_net_reader_fifo.sv
// Four-entry elastic buffer holding {last tag, weight word}.
// Head entry is presented combinationally from the read pointer; push and
// pop in the same cycle leave occupancy unchanged.
module gobou_net_reader_fifo
  import gobou_net_reader_pkg::*;
#(
  parameter int WIDTH = GOBOU_DWIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occupancy,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entries [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Never pop an empty buffer; never overwrite a full one unless it drains this cycle.
  assign do_pop  = pop && (occupancy != '0);
  assign do_push = push && ((occupancy != OCC_W'(FIFO_DEPTH)) || do_pop);

  assign head = entries[rd_ptr];

  // Storage, pointers and occupancy; reset empties the buffer and zeroes the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/gobou_net_reader.sv
// Read-side sequencer for the gobou network-weight RAM.
// Issues word addresses from a register, captures read_data one cycle later
// into a 4-entry buffer, and streams words out over valid/ready with a last
// tag on the final word of each segment.
// Optional build macro GOBOU_NET_READER_STAT_EN adds a saturating 32-bit
// stall_cycles counter (cycles with out_valid=1 and out_ready=0).
module gobou_net_reader
  import gobou_net_reader_pkg::*;
#(
  parameter int DWIDTH  = GOBOU_DWIDTH,
  parameter int NETSIZE = GOBOU_NETSIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [NETSIZE-1:0]       base_addr,
  input  logic [NETSIZE:0]         count,
  output logic                     busy,
  output logic                     done,
  output logic [NETSIZE-1:0]       mem_addr,
  input  logic signed [DWIDTH-1:0] read_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] out_data,
  output logic                     out_last
`ifdef GOBOU_NET_READER_STAT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam logic [NETSIZE:0] CNT_ONE = (NETSIZE + 1)'(1);

  state_t             state;
  logic [NETSIZE-1:0] next_addr;
  logic [NETSIZE:0]   issue_left;
  logic [NETSIZE:0]   recv_left;
  logic               inflight;

  logic [OCC_W-1:0]   occupancy;
  logic [OCC_W-1:0]   pending;
  logic [DWIDTH:0]    head;
  logic               head_last;
  logic               push_last;
  logic               accept;
  logic               issue;
  logic               pop;

  assign accept = (state == ST_IDLE) && req;

  // Issue decision uses only registered occupancy/inflight, so out_ready never
  // reaches mem_addr combinationally. Counting the in-flight read reserves its slot.
  assign pending = occupancy + OCC_W'(inflight);
  assign issue   = (state == ST_RUN) && (issue_left != '0) && (pending < OCC_W'(FIFO_DEPTH));

  assign push_last = (recv_left == CNT_ONE);
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;
  assign head_last = head[DWIDTH];
  assign out_data  = $signed(head[DWIDTH-1:0]);
  assign out_last  = head_last;

  gobou_net_reader_fifo #(
    .WIDTH(DWIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data({push_last, read_data}),
    .pop      (pop),
    .occupancy(occupancy),
    .head     (head)
  );

  // Segment sequencer: address issue, receive tagging, busy/done handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_addr   <= '0;
      next_addr  <= '0;
      issue_left <= '0;
      recv_left  <= '0;
      inflight   <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;

      if (issue) begin
        mem_addr   <= next_addr;
        next_addr  <= next_addr + NETSIZE'(1);
        issue_left <= issue_left - CNT_ONE;
      end

      if (inflight) begin
        recv_left <= recv_left - CNT_ONE;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (count != '0) begin
              next_addr  <= base_addr;
              issue_left <= count;
              recv_left  <= count;
              busy       <= 1'b1;
              state      <= ST_RUN;
            end else begin
              // Empty segment: acknowledge immediately without touching the RAM.
              done <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (issue && (issue_left == CNT_ONE)) begin
            state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          // Segment ends when the last-tagged word is accepted downstream.
          if (pop && head_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GOBOU_NET_READER_STAT_EN
  // Downstream back-pressure counter; restarts per segment and saturates.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gobou_net_reader.sv
// Self-checking bench for gobou_net_reader. RAM is modelled as mem[i]=i*3
// read from the registered mem_addr. A queue of expected words per segment is
// checked against every output handshake, with stall-stability checks and
// directed cycle-accurate expectations per scenario.
module tb_gobou_net_reader;

  localparam int DW = 16;
  localparam int NS = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 req;
  logic [NS-1:0]        base_addr;
  logic [NS:0]          count;
  logic                 busy;
  logic                 done;
  logic [NS-1:0]        mem_addr;
  logic signed [DW-1:0] read_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
`ifdef GOBOU_NET_READER_STAT_EN
  logic [31:0]          stall_cycles;
`endif

  // RAM contents mem[i] = i*3 truncated to the word width.
  always_comb read_data = DW'(32'(mem_addr) * 3);

  gobou_net_reader #(
    .DWIDTH (DW),
    .NETSIZE(NS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .read_data(read_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
`ifdef GOBOU_NET_READER_STAT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          delivered = 0;
  logic [DW:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic        prev_last = 1'b0;

  int first_k, last_k, done_k, n_valid, n_last, d0;
  logic busy_seen, valid_seen;
  int rpat[4] = '{1, 0, 0, 1};

  function automatic logic [31:0] d32(input logic [DW-1:0] v);
    return {16'b0, v};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference behaviour: words leave in order, exactly once, each equal to
  // mem[(base+i) mod 2**NS] with the last flag on the final one; a stalled
  // word must not change.
  task automatic scoreboard_cycle();
    logic [DW:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_data_held", d32(out_data), d32(prev_data));
        chk("stall_last_held", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && (exp_q.size() == 0)) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("word_data", d32(out_data), d32(e[DW-1:0]));
        chk("word_last", 32'(out_last), 32'(e[DW]));
        delivered++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    scoreboard_cycle();
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  // Presents req for one cycle; returns #1 after the accepting edge.
  task automatic start_req(input int b, input int c);
    logic [DW:0] e;
    req       = 1'b1;
    base_addr = NS'(b);
    count     = (NS + 1)'(c);
    for (int i = 0; i < c; i++) begin
      e[DW-1:0] = DW'(((b + i) % (1 << NS)) * 3);
      e[DW]     = (i == c - 1);
      exp_q.push_back(e);
    end
    sample();
    drive();
    req = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      sample();
      if (done) begin
        seen = 1'b1;
        chk({nm, "_busy_low_at_done"}, 32'(busy), 32'd0);
      end
      drive();
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
    repeat (3) @(posedge clk);
    #1;
    sample();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", d32(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    drive();
    rst = 1'b0;
    sample();
    drive();

    // Basic segment, full throughput.
    out_ready = 1'b1;
    start_req(10, 5);
    first_k = -1; last_k = -1; done_k = -1; n_valid = 0; n_last = 0;
    for (int k = 0; k < 12; k++) begin
      sample();
      if (k == 0) chk("t1_busy_after_req", 32'(busy), 32'd1);
      if (out_valid) begin
        n_valid++;
        if (first_k < 0) first_k = k;
      end
      if (k == 2) chk("t1_first_word", d32(out_data), 32'd30);
      if (k == 6) begin
        chk("t1_last_word", d32(out_data), 32'd42);
        chk("t1_last_flag", 32'(out_last), 32'd1);
      end
      if (out_valid && out_last) begin n_last++; last_k = k; end
      if (done) begin
        if (done_k < 0) done_k = k;
        chk("t1_busy_low_at_done", 32'(busy), 32'd0);
      end
      drive();
    end
    chk("t1_first_valid_cycle", 32'(first_k), 32'd2);
    chk("t1_last_cycle", 32'(last_k), 32'd6);
    chk("t1_done_cycle", 32'(done_k), 32'd7);
    chk("t1_valid_count", 32'(n_valid), 32'd5);
    chk("t1_last_count", 32'(n_last), 32'd1);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Address wrap at the top of the RAM.
    start_req((1 << NS) - 2, 4);
    n_valid = 0; done_k = -1;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (k == 1) chk("t2_addr0", 32'(mem_addr), 32'd16382);
      if (k == 2) chk("t2_addr1", 32'(mem_addr), 32'd16383);
      if (k == 3) chk("t2_addr2", 32'(mem_addr), 32'd0);
      if (k == 4) chk("t2_addr3", 32'(mem_addr), 32'd1);
      if (k == 2) chk("t2_word0", d32(out_data), 32'hBFFA);
      if (k == 4) chk("t2_word2", d32(out_data), 32'd0);
      if (out_valid && k >= 2 && k <= 5) n_valid++;
      if (done && done_k < 0) done_k = k;
      drive();
    end
    chk("t2_no_gaps", 32'(n_valid), 32'd4);
    chk("t2_done_cycle", 32'(done_k), 32'd6);

    // Full stall: issue stops once four words are buffered or in flight.
    out_ready = 1'b0;
    start_req(200, 8);
    for (int k = 0; k < 12; k++) begin
      sample();
      if (k == 4) chk("t3_addr_at_limit", 32'(mem_addr), 32'd203);
      if (k == 11) begin
        chk("t3_addr_held", 32'(mem_addr), 32'd203);
        chk("t3_valid_held", 32'(out_valid), 32'd1);
        chk("t3_head_word", d32(out_data), 32'd600);
      end
      drive();
    end
    out_ready = 1'b1;
    wait_done("t3", 40);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Ready toggling 1,0,0,1.
    d0 = delivered;
    out_ready = (rpat[0] != 0);
    start_req(100, 8);
    busy_seen = 1'b0;
    for (int k = 0; k < 80 && !busy_seen; k++) begin
      sample();
      if (done) busy_seen = 1'b1;
      drive();
      out_ready = (rpat[(k + 1) % 4] != 0);
    end
    chk("t4_done_seen", 32'(busy_seen), 32'd1);
    chk("t4_delivered", 32'(delivered - d0), 32'd8);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // count=0: immediate done, no busy, no data.
    out_ready = 1'b1;
    start_req(5, 0);
    busy_seen = 1'b0; valid_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("t5_done_pulse", 32'(done), (k == 0) ? 32'd1 : 32'd0);
      busy_seen  = busy_seen | busy;
      valid_seen = valid_seen | out_valid;
      drive();
    end
    chk("t5_busy_never", 32'(busy_seen), 32'd0);
    chk("t5_valid_never", 32'(valid_seen), 32'd0);

    // req while busy is ignored.
    d0 = delivered;
    start_req(50, 3);
    sample();
    drive();
    req = 1'b1; base_addr = NS'(200); count = (NS + 1)'(5);
    sample();
    drive();
    req = 1'b0;
    wait_done("t6", 20);
    for (int k = 0; k < 5; k++) begin
      sample();
      drive();
    end
    chk("t6_delivered", 32'(delivered - d0), 32'd3);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a segment with two words buffered.
    out_ready = 1'b0;
    start_req(300, 8);
    for (int k = 0; k < 4; k++) begin
      sample();
      if (k == 3) chk("t7_valid_before_rst", 32'(out_valid), 32'd1);
      if (k < 3) drive();
    end
    rst = 1'b1;
    reset_model();
    drive();
    rst = 1'b0;
    sample();
    chk("t7_valid_after_rst", 32'(out_valid), 32'd0);
    chk("t7_busy_after_rst", 32'(busy), 32'd0);
    chk("t7_addr_after_rst", 32'(mem_addr), 32'd0);
    chk("t7_done_after_rst", 32'(done), 32'd0);
    drive();
    out_ready = 1'b1;
    start_req(0, 1);
    done_k = -1;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (k == 2) begin
        chk("t7_single_valid", 32'(out_valid), 32'd1);
        chk("t7_single_data", d32(out_data), 32'd0);
        chk("t7_single_last", 32'(out_last), 32'd1);
      end
      if (done && done_k < 0) done_k = k;
      drive();
    end
    chk("t7_done_cycle", 32'(done_k), 32'd3);

`ifdef GOBOU_NET_READER_STAT_EN
    // Stall counter: six stalled cycles after the first valid word.
    out_ready = 1'b0;
    start_req(20, 4);
    for (int k = 0; k < 8; k++) begin
      sample();
      drive();
    end
    out_ready = 1'b1;
    wait_done("t8", 20);
    chk("t8_stall_cycles", stall_cycles, 32'd6);
    start_req(0, 1);
    sample();
    chk("t8_stall_cleared", stall_cycles, 32'd0);
    drive();
    wait_done("t8b", 20);
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
